sm_gen: RTL and testbench

Symbol-stream generator that drives the two-wire `a`/`b` symbol interface consumed by the `sm` state machine. It accepts a packed word of 2-bit symbols through a start/busy/done handshake. It replays the symbols MSB-first on `a`/`b`, holding each for a fixed number of clocks, then drives an idle gap. It is the transmitting end of the `sm` link, used to drive `sm` in the SM block and in system-level benches.

---
 rtl/sm_gen_if.sv | 12 +
 rtl/sm_gen.sv | 98 +++++++++
 tb/tb_sm_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/sm_gen_if.sv
// sm_gen_if: start/busy/done handshake plus the a/b symbol wires of the sm link.
interface sm_gen_if #(parameter int NSYM = 4);
   logic              start;
   logic [2*NSYM-1:0] data;
   logic              a;
   logic              b;
   logic              busy;
   logic              done;
   logic              err;
   modport master (output start, data, input a, b, busy, done, err);
   modport slave  (input start, data, output a, b, busy, done, err);
endinterface

// File: rtl/sm_gen.sv
// sm_gen: replays a packed word of 2-bit symbols MSB-first on a/b, each held HOLD clocks, then GAP idle clocks.
module sm_gen #(
   parameter int NSYM = 4,
   parameter int HOLD = 3,
   parameter int GAP  = 2
) (
   input  logic    En,
   input  logic    rst,
   sm_gen_if.slave s
);
   localparam int W  = 2 * NSYM;
   localparam int SW = $clog2(NSYM + 1);
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;
   state_t         state_q, state_d;
   logic [W-1:0]   sr_q, sr_d;
   logic [SW-1:0]  sym_q, sym_d;
   logic [7:0]     hold_q, hold_d;
   logic [7:0]     gap_q, gap_d;
   logic           a_q, a_d, b_q, b_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic           accept, last_hold, last_sym, snd, ill;
   logic [1:0]     cur;
   assign accept    = s.start && (state_q == S_IDLE || state_q == S_DONE);
   assign last_hold = hold_q == 8'(HOLD - 1);
   assign last_sym  = sym_q == SW'(NSYM - 1);
   always_ff @(posedge En or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         sym_q   <= '0;
         hold_q  <= '0;
         gap_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         sym_q   <= sym_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      sym_d   = sym_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      case (state_q)
         S_SEND: begin
            hold_d = last_hold ? 8'd0 : hold_q + 8'd1;
            if (last_hold) begin
               sr_d  = sr_q << 2;
               sym_d = sym_q + 1'b1;
               if (last_sym) begin
                  state_d = (GAP == 0) ? S_DONE : S_GAP;
                  gap_d   = 8'd0;
               end
            end
         end
         S_GAP: begin
            gap_d = gap_q + 8'd1;
            if (gap_q == 8'(GAP - 1)) state_d = S_DONE;
         end
         default: begin
            state_d = accept ? S_SEND : S_IDLE;
            if (accept) begin
               sr_d   = s.data;
               sym_d  = '0;
               hold_d = 8'd0;
            end
         end
      endcase
   end
   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      cur    = sr_d[W-1 -: 2];
      ill    = &cur;
      snd    = state_d == S_SEND;
      a_d    = snd & cur[1] & ~ill;
      b_d    = snd & cur[0] & ~ill;
      busy_d = snd | (state_d == S_GAP);
      done_d = state_d == S_DONE;
      err_d  = (err_q & ~accept) | (snd & ill);
   end
   assign s.a    = a_q;
   assign s.b    = b_q;
   assign s.busy = busy_q;
   assign s.done = done_q;
   assign s.err  = err_q;
endmodule

// File: tb/tb_sm_gen.sv
// tb_sm_gen: directed checks of sm_gen with default parameters and the NSYM=1/HOLD=1/GAP=0 corner.
module tb_sm_gen;
   logic En, rst;
   int   n_vec = 0, n_err = 0;
   sm_gen_if #(.NSYM(4)) i0();
   sm_gen_if #(.NSYM(1)) i1();
   sm_gen #(.NSYM(4), .HOLD(3), .GAP(2)) u0 (.En(En), .rst(rst), .s(i0));
   sm_gen #(.NSYM(1), .HOLD(1), .GAP(0)) u1 (.En(En), .rst(rst), .s(i1));
   initial begin
      En = 1'b0;
      forever #5 En = ~En;
   end
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick;
      @(posedge En);
      #1;
   endtask
   // One message on u0 from IDLE; optionally pulses start in cycles 5 and 13 with other data.
   task automatic send(input logic [7:0] d, input bit ign);
      logic [1:0] sy, e_ab;
      logic       e_err;
      int         j;
      i0.start = 1'b1;
      i0.data  = d;
      tick;
      i0.start = 1'b0;
      i0.data  = 8'h00;
      e_err    = 1'b0;
      for (int n = 1; n <= 15; n++) begin
         j = (n - 1) / 3;
         e_ab = 2'b00;
         if (n <= 12) begin
            sy    = d[7-2*j -: 2];
            e_err = e_err | (&sy);
            e_ab  = (&sy) ? 2'b00 : sy;
         end
         chk($sformatf("ab c%0d", n), {6'b0, i0.a, i0.b}, {6'b0, e_ab});
         chk($sformatf("busy c%0d", n), {7'b0, i0.busy}, {7'b0, n <= 14});
         chk($sformatf("done c%0d", n), {7'b0, i0.done}, {7'b0, n == 15});
         chk($sformatf("err c%0d", n), {7'b0, i0.err}, {7'b0, e_err});
         if (ign && (n == 5 || n == 13)) begin
            i0.start = 1'b1;
            i0.data  = ~d;
         end else i0.start = 1'b0;
         tick;
      end
   endtask
   initial begin
      int bad;
      rst = 1'b1;
      i0.start = 1'b0; i0.data = '0;
      i1.start = 1'b0; i1.data = '0;
      #1;
      chk("rst outs", {3'b0, i0.a, i0.b, i0.busy, i0.done, i0.err}, 8'h00);
      #2 rst = 1'b0;
      // Corner instance: single symbol, single-clock hold, no gap.
      i1.start = 1'b1; i1.data = 2'b10;
      tick;
      i1.start = 1'b0;
      chk("c1 ab", {6'b0, i1.a, i1.b}, 8'h02);
      chk("c1 busy", {7'b0, i1.busy}, 8'h01);
      chk("c1 done", {7'b0, i1.done}, 8'h00);
      tick;
      chk("c2 ab", {6'b0, i1.a, i1.b}, 8'h00);
      chk("c2 busy", {7'b0, i1.busy}, 8'h00);
      chk("c2 done", {7'b0, i1.done}, 8'h01);
      tick;
      chk("c3 done", {7'b0, i1.done}, 8'h00);
      // Basic send, ignored starts, illegal symbol and err clearing.
      send(8'b10_01_00_10, 1'b0);
      send(8'b10_01_00_10, 1'b1);
      send(8'b11_10_00_01, 1'b0);
      chk("err sticky idle", {7'b0, i0.err}, 8'h01);
      send(8'b10_01_00_10, 1'b0);
      // Asynchronous reset mid-SEND.
      i0.start = 1'b1; i0.data = 8'b11_10_01_10;
      tick;
      i0.start = 1'b0;
      repeat (4) tick;
      chk("pre-rst ab", {6'b0, i0.a, i0.b}, 8'h02);
      chk("pre-rst err", {7'b0, i0.err}, 8'h01);
      #2 rst = 1'b1;
      #1;
      chk("async rst outs", {3'b0, i0.a, i0.b, i0.busy, i0.done, i0.err}, 8'h00);
      #2 rst = 1'b0;
      bad = 0;
      repeat (20) begin
         tick;
         if (i0.done || i0.busy) bad++;
      end
      chk("no done after rst", 8'(bad), 8'h00);
      // Back-to-back with start held high.
      i0.start = 1'b1; i0.data = 8'b01_01_01_01;
      tick;
      for (int n = 1; n <= 45; n++) begin
         chk($sformatf("b2b done c%0d", n), {7'b0, i0.done}, {7'b0, n % 15 == 0});
         chk($sformatf("b2b ab c%0d", n), {6'b0, i0.a, i0.b},
             {6'b0, (n % 15 >= 1 && n % 15 <= 12) ? 2'b01 : 2'b00});
         tick;
      end
      i0.start = 1'b0;
      repeat (16) tick;
      chk("b2b idle busy", {7'b0, i0.busy}, 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
